// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage load/store unit: SRAM-like bus handshake, store encoding, load extension, address errors
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [7:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_in,
    input  logic        flush_except,
    input  logic        pipe_advance,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic [31:0] load_result,
    output logic        mem_stall,
    output logic        adel,
    output logic        ades,
    output logic [31:0] badvaddr
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL, S_DISCARD
    } state_t;

    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [7:0]  r_op;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [3:0]  r_wstrb;

    logic        w_is_load, w_is_store, w_mis, w_mem_ok, w_go;
    logic [1:0]  w_size;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic        w_req, w_use_reg, w_capture, w_latch;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size     = 2'd0;
        w_wstrb    = 4'b0000;
        w_wdata    = 32'd0;
        w_mis      = 1'b0;
        case (op)
            EXE_LB_OP, EXE_LBU_OP: begin
                w_is_load = 1'b1;
                w_size    = 2'd0;
            end
            EXE_LH_OP, EXE_LHU_OP: begin
                w_is_load = 1'b1;
                w_size    = 2'd1;
                w_mis     = addr[0];
            end
            EXE_LW_OP: begin
                w_is_load = 1'b1;
                w_size    = 2'd2;
                w_mis     = |addr[1:0];
            end
            EXE_SB_OP: begin
                w_is_store = 1'b1;
                w_size     = 2'd0;
                w_wstrb    = 4'b0001 << addr[1:0];
                w_wdata    = {4{wdata_in[7:0]}};
            end
            EXE_SH_OP: begin
                w_is_store = 1'b1;
                w_size     = 2'd1;
                w_wstrb    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{wdata_in[15:0]}};
                w_mis      = addr[0];
            end
            EXE_SW_OP: begin
                w_is_store = 1'b1;
                w_size     = 2'd2;
                w_wstrb    = 4'b1111;
                w_wdata    = wdata_in;
                w_mis      = |addr[1:0];
            end
            default: ;
        endcase
    end

    // Reset also gates the combinational outputs so the bus sees nothing while rst is low.
    assign adel      = rst & valid_i & w_is_load & w_mis;
    assign ades      = rst & valid_i & w_is_store & w_mis;
    assign badvaddr  = (adel | ades) ? addr : 32'd0;
    assign w_mem_ok  = rst & valid_i & (w_is_load | w_is_store) & ~w_mis;
    assign w_go      = w_mem_ok & ~flush_except;
    assign mem_stall = w_go & (r_state != S_DONE);

    always_comb begin
        w_next    = r_state;
        w_req     = 1'b0;
        w_use_reg = 1'b0;
        w_capture = 1'b0;
        w_latch   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req     = w_go;
                w_capture = w_go;
                if (w_go)
                    w_next = data_sram_addr_ok ? S_WAIT : S_REQ;
            end
            S_REQ: begin
                w_req     = 1'b1;
                w_use_reg = 1'b1;
                // An accepted request still owes a response, so a flush must drain it.
                if (flush_except)
                    w_next = data_sram_addr_ok ? S_DISCARD : S_CANCEL;
                else if (data_sram_addr_ok)
                    w_next = S_WAIT;
            end
            S_WAIT: begin
                if (flush_except)
                    w_next = data_sram_data_ok ? S_IDLE : S_DISCARD;
                else if (data_sram_data_ok) begin
                    w_latch = 1'b1;
                    w_next  = S_DONE;
                end
            end
            S_DONE: begin
                if (pipe_advance || flush_except)
                    w_next = S_IDLE;
            end
            S_CANCEL: begin
                w_req     = 1'b1;
                w_use_reg = 1'b1;
                if (data_sram_addr_ok)
                    w_next = S_DISCARD;
            end
            S_DISCARD: begin
                if (data_sram_data_ok)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_op    <= 8'd0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_wstrb <= 4'b0000;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_addr  <= addr;
                r_wdata <= w_wdata;
                r_op    <= op;
                r_wr    <= w_is_store;
                r_size  <= w_size;
                r_wstrb <= w_wstrb;
            end
            if (w_latch)
                r_rdata <= data_sram_rdata;
        end
    end

    always_comb begin
        data_sram_req   = w_req;
        data_sram_wr    = 1'b0;
        data_sram_size  = 2'd0;
        data_sram_wstrb = 4'b0000;
        data_sram_addr  = 32'd0;
        data_sram_wdata = 32'd0;
        if (w_req && w_use_reg) begin
            data_sram_wr    = r_wr;
            data_sram_size  = r_size;
            data_sram_wstrb = r_wstrb;
            data_sram_addr  = r_addr;
            data_sram_wdata = r_wdata;
        end else if (w_req) begin
            data_sram_wr    = w_is_store;
            data_sram_size  = w_size;
            data_sram_wstrb = w_wstrb;
            data_sram_addr  = addr;
            data_sram_wdata = w_wdata;
        end
    end

    always_comb begin
        w_byte = 8'd0;
        case (r_addr[1:0])
            2'd0: w_byte = r_rdata[7:0];
            2'd1: w_byte = r_rdata[15:8];
            2'd2: w_byte = r_rdata[23:16];
            2'd3: w_byte = r_rdata[31:24];
            default: ;
        endcase
        w_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];
        load_result = 32'd0;
        if (r_state == S_DONE && !r_wr) begin
            case (r_op)
                EXE_LB_OP:  load_result = {{24{w_byte[7]}}, w_byte};
                EXE_LBU_OP: load_result = {24'd0, w_byte};
                EXE_LH_OP:  load_result = {{16{w_half[15]}}, w_half};
                EXE_LHU_OP: load_result = {16'd0, w_half};
                EXE_LW_OP:  load_result = r_rdata;
                default:    load_result = 32'd0;
            endcase
        end
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM-stage load/store unit sitting directly downstream of the ALU. It takes the ALU result (effective address), the 8-bit op and the rt store data.
- It drives an SRAM-like data bus with a request/addr_ok/data_ok handshake and generates byte strobes and replicated write data.
- It aligns and sign/zero-extends load data, detects address-error exceptions, and stalls the pipeline until the access completes.

Parameters:
- none (all widths fixed at 32-bit data/address; op encodings come from defines.vh)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- valid_i  in  1  MEM stage holds a valid instruction
- op  in  8  EXE_*_OP code; LW/LB/LBU/LH/LHU/SW/SB/SH are memory ops, all others are ignored
- addr  in  32  effective address (ALU y)
- wdata_in  in  32  store source (rt)
- flush_except  in  1  exception flush of the pipeline
- pipe_advance  in  1  downstream accepts the MEM result this cycle
- data_sram_req  out  1  bus request
- data_sram_wr  out  1  1 = store
- data_sram_size  out  2  0 = byte, 1 = half, 2 = word
- data_sram_wstrb  out  4  byte enables (stores only; 0 on loads)
- data_sram_addr  out  32  access address (= addr, unaligned low bits kept)
- data_sram_wdata  out  32  replicated store data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  response (read data valid / write done)
- data_sram_rdata  in  32  raw read word
- load_result  out  32  extended load value
- mem_stall  out  1  hold pipeline
- adel  out  1  load address error
- ades  out  1  store address error
- badvaddr  out  32  faulting address

Behaviour:
- go = valid_i & memory op & ~adel & ~ades & ~flush_except.
- Misalignment rules:
  - LW: addr[1:0] != 0 → adel.
  - LH/LHU: addr[0] != 0 → adel.
  - SW, SH: same alignment rules → ades.
  - adel/ades/badvaddr are combinational; badvaddr = addr when either is set, else 0.
  - A faulting op issues no request and raises no stall.
- FSM states: IDLE, REQ, WAIT, DONE, CANCEL, DISCARD. Reset → IDLE, and every registered output/latch clears to 0.
- IDLE:
  - data_sram_req = go.
  - go & addr_ok → WAIT.
  - go & ~addr_ok → REQ.
- REQ:
  - req = 1, with addr/wr/size/wstrb/wdata held from registered copies captured on entry.
  - addr_ok → WAIT.
  - flush_except → CANCEL (req stays high; a request is never withdrawn).
- WAIT:
  - data_ok → latch rdata and → DONE.
  - flush_except → DISCARD.
- DONE:
  - load_result valid.
  - pipe_advance → IDLE.
  - flush_except → IDLE.
- CANCEL: req = 1 until addr_ok → DISCARD.
- DISCARD: wait for data_ok, drop the data → IDLE.
- The bus guarantees data_ok no earlier than the cycle after addr_ok. Only one outstanding access is allowed.
- mem_stall:
  - 1 when valid_i & memory op & no address error and state is IDLE, REQ or WAIT (not DONE).
  - Also 1 in CANCEL/DISCARD if a new memory op is presented.
  - 0 in the cycle a flush is taken.
- Minimum latency: req in cycle 0 with addr_ok, data_ok in cycle 1, DONE in cycle 2. mem_stall is high in cycles 0–1.
- Store encoding:
  - SB: size 0, wstrb = 1 << addr[1:0], wdata = {4{wdata_in[7:0]}}.
  - SH: size 1, wstrb = 0011 or 1100 by addr[1], wdata = {2{wdata_in[15:0]}}.
  - SW: size 2, wstrb = 1111.
- Load extension: select the byte by addr[1:0] or the half by addr[1] from the latched rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - load_result = 0 outside DONE and for stores.
- Simultaneous events:
  - flush_except has priority over addr_ok/data_ok decisions except where the bus protocol forces CANCEL/DISCARD.
  - data_ok in DONE is illegal (no outstanding access).
- Reset mid-access (rst = 0) forces IDLE immediately; the bus side is reset simultaneously.

Test Plan:
- LB, addr 0x1003, rdata 0x80FF_1234, addr_ok at cycle 0, data_ok at cycle 1 → size 0, wstrb 0, load_result 0xFFFF_FF80 in DONE; mem_stall high for exactly 2 cycles.
- SH, addr 0x2002, wdata_in 0x1234_ABCD → req, wr = 1, size 1, wstrb 1100, wdata 0xABCD_ABCD; LHU at 0x2002 with rdata 0xABCD_0000 → 0x0000_ABCD.
- LW, addr 0x3001 → adel = 1, badvaddr 0x3001, no req, mem_stall 0; SW at 0x3002 → ades = 1.
- addr_ok withheld 3 cycles then data_ok 2 cycles later → req held with a stable address, mem_stall high for 6 cycles total, one DONE cycle until pipe_advance.
- flush_except in WAIT → DISCARD; the later data_ok with rdata 0xDEAD_BEEF does not appear on load_result; a subsequent LW completes normally.
- rst driven low in REQ → state IDLE and req = 0 immediately (asynchronously); all outputs 0 until rst returns high.
